avmm_stream_writer: RTL

- Avalon-MM write master that takes a valid/ready stream of 32-bit result words (e.g. per-row detection results from the camera pipeline) and writes them to consecutive word addresses of the on-chip memory slave (32-bit, 15-bit word address, byteenable).
- Software, or a control FSM, programs a base address and word count, then pulses start.
- The block buffers words in a small FIFO, honours waitrequest, wraps the address, and signals completion.

---
 rtl/avmm_stream_writer_if.sv | 44 ++++
 rtl/avmm_stream_writer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/avmm_stream_writer_if.sv
// Bundle of the control, stream-sink and Avalon-MM master signals of avmm_stream_writer.
// The master modport is the writer's view; the slave modport is the surrounding system's view.
interface avmm_stream_writer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                  cfg_start;
  logic                  cfg_abort;
  logic [ADDR_W-1:0]     cfg_base;
  logic [CNT_W-1:0]      cfg_count;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  logic                  snk_valid;
  logic [DATA_W-1:0]     snk_data;
  logic                  snk_ready;

  logic [ADDR_W-1:0]     avm_address;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_chipselect;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic                  avm_waitrequest;

  modport master (
    input  cfg_start, cfg_abort, cfg_base, cfg_count,
    output busy, done, aborted,
    input  snk_valid, snk_data,
    output snk_ready,
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_base, cfg_count,
    input  busy, done, aborted,
    output snk_valid, snk_data,
    input  snk_ready,
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/avmm_stream_writer.sv
// Avalon-MM write master: buffers a valid/ready word stream in a small FIFO and writes it
// to consecutive (wrapping) word addresses starting at a programmed base.
module avmm_stream_writer #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  avmm_stream_writer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem_acc;
  logic [CNT_W-1:0]  rem_wr;
  logic              aborted_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    fill;

  logic fifo_full;
  logic fifo_empty;
  logic wr_req;
  logic wr_done;
  logic push;
  logic start_ok;
  logic abort_run;
  logic snk_ready_c;
  logic busy_c;
  logic done_c;

  assign fifo_full  = (fill == FILL_FULL);
  assign fifo_empty = (fill == '0);

  // The FIFO head is the presented write: it stays in place (address, data and request
  // stable) until the slave accepts it, so no separate output holding register is needed.
  assign wr_req    = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty;
  assign wr_done   = wr_req && !bus.avm_waitrequest;
  assign start_ok  = (state == S_IDLE) && bus.cfg_start;
  assign abort_run = (state == S_RUN) && bus.cfg_abort;
  assign push      = snk_ready_c && bus.snk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    snk_ready_c = 1'b0;
    busy_c      = (state != S_IDLE);
    done_c      = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_nx = (bus.cfg_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        snk_ready_c = !bus.cfg_abort && !fifo_full && (rem_acc != '0);
        if (bus.cfg_abort) begin
          state_nx = (wr_req && bus.avm_waitrequest) ? S_DRAIN : S_DONE;
        end else if (wr_done && (rem_wr == CNT_W'(1))) begin
          state_nx = S_DONE;
        end
      end
      S_DRAIN: begin
        if (!wr_req || !bus.avm_waitrequest) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      rem_acc   <= '0;
      rem_wr    <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr      <= bus.cfg_base;
        rem_acc   <= bus.cfg_count;
        rem_wr    <= bus.cfg_count;
        aborted_q <= 1'b0;
      end
      if (abort_run) begin
        aborted_q <= 1'b1;
      end
      if (push) begin
        rem_acc <= rem_acc - CNT_W'(1);
      end
      if (wr_done) begin
        addr   <= addr + ADDR_W'(1);
        rem_wr <= rem_wr - CNT_W'(1);
      end
    end
  end

  // Abort keeps only a stalled head word (it must still complete); all other words are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (abort_run) begin
      rd_ptr <= rd_ptr + PTR_W'(wr_done);
      wr_ptr <= rd_ptr + PTR_W'(wr_req);
      fill   <= (wr_req && bus.avm_waitrequest) ? (PTR_W+1)'(1) : '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(wr_done);
      wr_ptr <= wr_ptr + PTR_W'(push);
      fill   <= fill + (PTR_W+1)'(push) - (PTR_W+1)'(wr_done);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.snk_data;
    end
  end

  assign bus.snk_ready      = snk_ready_c;
  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.aborted        = aborted_q;
  assign bus.avm_address    = addr;
  assign bus.avm_byteenable = '1;
  assign bus.avm_write      = wr_req;
  assign bus.avm_chipselect = wr_req;
  assign bus.avm_writedata  = wr_req ? mem[rd_ptr] : '0;

endmodule
